// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The stream source and the memory side both attach through the master modport.
interface imem_loader_if #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned address_width = 32
);
  logic [7:0]               in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     mem_we;
  logic [address_width-1:0] mem_addr;
  logic [data_width-1:0]    mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles big-endian words from a byte
// stream (header word count, then N words) and holds the CPU until loaded.
module imem_loader #(
  parameter int unsigned data_width    = 32,
  parameter int unsigned address_width = 32,
  parameter int unsigned mem_depth     = 262144,
  parameter logic [31:0] base_address  = 32'h80020000
) (
  input  logic                     clock,
  input  logic                     reset,
  imem_loader_if.slave             bus,
  output logic [address_width-1:0] loaded_words,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERROR} state_t;

  state_t                   state;
  logic [1:0]               byte_count;
  logic [data_width-1:0]    sr;
  logic [31:0]              word_count;
  logic                     accept;
  logic [data_width-1:0]    word_next;
  logic [address_width-1:0] next_loaded;

  assign accept      = bus.in_valid && bus.in_ready;
  assign word_next   = {sr[data_width-9:0], bus.in_data};
  assign next_loaded = loaded_words + address_width'(1);

  // in_ready is registered, so it only goes high one cycle after IDLE->HDR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      byte_count    <= 2'd0;
      sr            <= '0;
      word_count    <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= address_width'(base_address);
      bus.mem_wdata <= '0;
      loaded_words  <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= HDR;
          byte_count <= 2'd0;
        end

        HDR: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            sr         <= word_next;
            byte_count <= byte_count + 2'd1;
            if (byte_count == 2'd3) begin
              word_count <= word_next;
              if (word_next == '0) begin
                state        <= DONE;
                bus.in_ready <= 1'b0;
                cpu_hold     <= 1'b0;
                done         <= 1'b1;
              end else if (word_next > mem_depth) begin
                state        <= ERROR;
                bus.in_ready <= 1'b0;
                error        <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (accept) begin
            sr         <= word_next;
            byte_count <= byte_count + 2'd1;
            if (byte_count == 2'd3) begin
              state         <= WRITE;
              bus.in_ready  <= 1'b0;
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= word_next;
            end
          end
        end

        // mem_addr advances with loaded_words so it always equals base + 4*loaded_words.
        WRITE: begin
          bus.mem_we   <= 1'b0;
          loaded_words <= next_loaded;
          bus.mem_addr <= bus.mem_addr + address_width'(4);
          if (next_loaded < address_width'(word_count)) begin
            state        <= DATA;
            bus.in_ready <= 1'b1;
          end else begin
            state    <= DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end

        DONE, ERROR: begin
          state <= state;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset values, word loads with and without
// bubbles, empty and oversize images, and reset in the middle of a word.
module tb_imem_loader;

  localparam logic [31:0] base = 32'h80020000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [31:0] loaded_words;
  logic cpu_hold;
  logic done;
  logic error;

  imem_loader_if bus ();

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .loaded_words (loaded_words),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCycle[$];
  logic [7:0]  stimBytes[$];

  always @(posedge clock) cycle++;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.mem_we) begin
      wrAddr.push_back(bus.mem_addr);
      wrData.push_back(bus.mem_wdata);
      wrCycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset        = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  // Must be called at a negedge; returns at the negedge after the accepting edge.
  task automatic sendByte(input logic [7:0] b);
    int waitCycles = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!bus.in_ready) begin
      checkOutput("ready_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int gap);
    for (int i = 0; i < stimBytes.size(); i++) begin
      if (i != 0) repeat (gap) @(negedge clock);
      sendByte(stimBytes[i]);
    end
  endtask

  task automatic loadThreeWords(input int gap, input string name);
    int startIdx;
    startIdx  = wrAddr.size();
    stimBytes = '{8'h00, 8'h00, 8'h00, 8'h03,
                  8'h3C, 8'h1D, 8'h80, 8'h02,
                  8'h27, 8'hBD, 8'hFF, 8'hF0,
                  8'h00, 8'h00, 8'h00, 8'h0D};
    applyStimulus(gap);
    checkOutput({name, "_we_last"}, 64'(bus.mem_we), 64'd1);
    checkOutput({name, "_hold_before_done"}, 64'(cpu_hold), 64'd1);
    @(negedge clock);
    checkOutput({name, "_wr_count"}, 64'(wrAddr.size() - startIdx), 64'd3);
    if (wrAddr.size() - startIdx == 3) begin
      checkOutput({name, "_addr0"}, 64'(wrAddr[startIdx]),   64'h80020000);
      checkOutput({name, "_data0"}, 64'(wrData[startIdx]),   64'h3C1D8002);
      checkOutput({name, "_addr1"}, 64'(wrAddr[startIdx+1]), 64'h80020004);
      checkOutput({name, "_data1"}, 64'(wrData[startIdx+1]), 64'h27BDFFF0);
      checkOutput({name, "_addr2"}, 64'(wrAddr[startIdx+2]), 64'h80020008);
      checkOutput({name, "_data2"}, 64'(wrData[startIdx+2]), 64'h0000000D);
      if (gap == 0) begin
        checkOutput({name, "_spacing01"}, 64'(wrCycle[startIdx+1] - wrCycle[startIdx]),   64'd5);
        checkOutput({name, "_spacing12"}, 64'(wrCycle[startIdx+2] - wrCycle[startIdx+1]), 64'd5);
      end
    end
    checkOutput({name, "_done"},   64'(done),         64'd1);
    checkOutput({name, "_hold"},   64'(cpu_hold),     64'd0);
    checkOutput({name, "_loaded"}, 64'(loaded_words), 64'd3);
    checkOutput({name, "_we_off"}, 64'(bus.mem_we),   64'd0);
    checkOutput({name, "_ready"},  64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    int startIdx;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values and in_ready rising on the second edge after release.
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_hold",   64'(cpu_hold),      64'd1);
    checkOutput("rst_we",     64'(bus.mem_we),    64'd0);
    checkOutput("rst_addr",   64'(bus.mem_addr),  64'(base));
    checkOutput("rst_ready",  64'(bus.in_ready),  64'd0);
    checkOutput("rst_wdata",  64'(bus.mem_wdata), 64'd0);
    checkOutput("rst_loaded", 64'(loaded_words),  64'd0);
    checkOutput("rst_done",   64'(done),          64'd0);
    checkOutput("rst_error",  64'(error),         64'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("ready_edge1", 64'(bus.in_ready), 64'd0);
    @(negedge clock);
    checkOutput("ready_edge2", 64'(bus.in_ready), 64'd1);

    loadThreeWords(0, "load");

    doReset();
    loadThreeWords(2, "bubble");

    // Empty image.
    doReset();
    startIdx  = wrAddr.size();
    stimBytes = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("empty_done",   64'(done),         64'd1);
    checkOutput("empty_hold",   64'(cpu_hold),     64'd0);
    checkOutput("empty_loaded", 64'(loaded_words), 64'd0);
    repeat (5) @(negedge clock);
    checkOutput("empty_no_write", 64'(wrAddr.size() - startIdx), 64'd0);

    // Oversize image: mem_depth + 1 words.
    doReset();
    startIdx  = wrAddr.size();
    stimBytes = '{8'h00, 8'h04, 8'h00, 8'h01};
    applyStimulus(0);
    checkOutput("over_error", 64'(error),        64'd1);
    checkOutput("over_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("over_hold",  64'(cpu_hold),     64'd1);
    checkOutput("over_done",  64'(done),         64'd0);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (10) @(negedge clock);
    bus.in_valid = 1'b0;
    checkOutput("over_no_write",   64'(wrAddr.size() - startIdx), 64'd0);
    checkOutput("over_ready_late", 64'(bus.in_ready), 64'd0);
    checkOutput("over_error_late", 64'(error),        64'd1);

    // Reset in the middle of word 0, then a clean two-word reload.
    doReset();
    startIdx  = wrAddr.size();
    stimBytes = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22};
    applyStimulus(0);
    reset = 1'b0;
    #1;
    checkOutput("mid_ready",  64'(bus.in_ready),  64'd0);
    checkOutput("mid_we",     64'(bus.mem_we),    64'd0);
    checkOutput("mid_addr",   64'(bus.mem_addr),  64'(base));
    checkOutput("mid_hold",   64'(cpu_hold),      64'd1);
    checkOutput("mid_loaded", 64'(loaded_words),  64'd0);
    @(negedge clock);
    doReset();
    stimBytes = '{8'h00, 8'h00, 8'h00, 8'h02,
                  8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h01, 8'h23, 8'h45, 8'h67};
    applyStimulus(0);
    @(negedge clock);
    checkOutput("reload_wr_count", 64'(wrAddr.size() - startIdx), 64'd2);
    if (wrAddr.size() - startIdx == 2) begin
      checkOutput("reload_addr0", 64'(wrAddr[startIdx]),   64'h80020000);
      checkOutput("reload_data0", 64'(wrData[startIdx]),   64'hDEADBEEF);
      checkOutput("reload_addr1", 64'(wrAddr[startIdx+1]), 64'h80020004);
      checkOutput("reload_data1", 64'(wrData[startIdx+1]), 64'h01234567);
    end
    checkOutput("reload_done",   64'(done),         64'd1);
    checkOutput("reload_loaded", 64'(loaded_words), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
